// File: rtl/btn_debounce_toggle.sv
// Per-lane button conditioner: 2-flop synchroniser, debounce counter, registered
// press/release pulses and a press-driven LED toggle register.
module btn_debounce_toggle #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btns,
  input  logic             led_clr,
  output logic [WIDTH-1:0] btn_state,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] leds
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] release_q, release_d;
  logic [WIDTH-1:0] leds_q, leds_d;

  // A differing run of DEBOUNCE_CYCLES samples is accepted on the edge the
  // counter sits at its last value; any matching sample restarts the run.
  always_comb begin
    cnt_d     = cnt_q;
    state_d   = state_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == state_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        cnt_d[i]     = '0;
        state_d[i]   = s2_q[i];
        press_d[i]   = s2_q[i];
        release_d[i] = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end
    end
    // Toggle uses the press being registered now, so the LED moves with the pulse.
    leds_d = led_clr ? '0 : (leds_q ^ press_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      cnt_q     <= '{default: '0};
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      leds_q    <= '0;
    end else begin
      s1_q      <= btns;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      leds_q    <= leds_d;
    end
  end

  assign btn_state     = state_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign leds          = leds_q;

endmodule

// File: tb/tb_btn_debounce_toggle.sv
// Bench for btn_debounce_toggle: directed scenarios plus random stimulus checked
// against a sample-window reference model.
module tb_btn_debounce_toggle;

  localparam int W   = 8;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] btns = '0;
  logic         led_clr = 1'b0;
  logic [W-1:0] btn_state, press_pulse, release_pulse, leds;

  int n_checks = 0;
  int n_fail   = 0;

  btn_debounce_toggle #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk          (clk),
    .rst          (rst),
    .btns         (btns),
    .led_clr      (led_clr),
    .btn_state    (btn_state),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .leds         (leds)
  );

  always #5 clk = ~clk;

  // Model: a level is accepted when the last DEB synchronised samples all
  // differ from the current debounced level. smp[0] is the newest raw sample,
  // smp[1] is what the synchroniser presents at the coming edge.
  logic [W-1:0] smp [0:DEB];
  logic [W-1:0] m_state = '0, m_press = '0, m_rel = '0, m_leds = '0;

  task automatic model_edge();
    logic [W-1:0] acc;
    if (rst) begin
      for (int j = 0; j <= DEB; j++) smp[j] = '0;
      m_state = '0; m_press = '0; m_rel = '0; m_leds = '0;
    end else begin
      acc = '1;
      for (int j = 1; j <= DEB; j++) acc &= (smp[j] ^ m_state);
      m_press = acc & smp[1];
      m_rel   = acc & ~smp[1];
      m_state = m_state ^ acc;
      m_leds  = led_clr ? '0 : (m_leds ^ m_press);
      for (int j = DEB; j > 0; j--) smp[j] = smp[j-1];
      smp[0] = btns;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; btns = 8'hFF; led_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({btn_state, press_pulse, release_pulse, leds} !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h %h %h %h required all 0", btn_state, press_pulse, release_pulse, leds);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      n_checks++;
      if (press_pulse !== ((i == 6) ? 8'hFF : 8'h00)) begin
        n_fail++;
        $display("FAIL reset_press_latency edge %0d: got %h required %h", i, press_pulse, (i == 6) ? 8'hFF : 8'h00);
      end
      n_checks++;
      if (btn_state !== ((i >= 6) ? 8'hFF : 8'h00)) begin
        n_fail++;
        $display("FAIL reset_state_latency edge %0d: got %h", i, btn_state);
      end
    end
    n_checks++;
    if (leds !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_leds: got %h required ff", leds);
    end
  endtask

  task automatic test_single_press();
    int pc, rc, other;
    rst = 1'b1; btns = 8'h00; tick(); tick(); rst = 1'b0;
    btns = 8'h02; pc = 0; other = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pc += int'(press_pulse[1]);
      other += $countones(press_pulse & 8'hFD) + $countones(release_pulse);
    end
    n_checks++;
    if (pc != 1 || other != 0) begin
      n_fail++;
      $display("FAIL single_press_pulses: got %0d/%0d required 1/0", pc, other);
    end
    n_checks++;
    if (leds !== 8'h02 || btn_state !== 8'h02) begin
      n_fail++;
      $display("FAIL single_press_leds: got leds %h state %h required 02 02", leds, btn_state);
    end
    btns = 8'h00; rc = 0; pc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      rc += int'(release_pulse[1]);
      pc += $countones(press_pulse);
    end
    n_checks++;
    if (rc != 1 || pc != 0) begin
      n_fail++;
      $display("FAIL single_release_pulses: got rel %0d press %0d required 1 0", rc, pc);
    end
    n_checks++;
    if (leds !== 8'h02) begin
      n_fail++;
      $display("FAIL release_keeps_leds: got %h required 02", leds);
    end
    btns = 8'h02;
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (leds !== 8'h00) begin
      n_fail++;
      $display("FAIL second_press_leds: got %h required 00", leds);
    end
  endtask

  task automatic test_glitch();
    int pc, rc;
    pc = 0; rc = 0;
    btns = 8'h0A;
    for (int i = 0; i < 3; i++) begin tick(); pc += int'(press_pulse[3]); rc += int'(release_pulse[3]); end
    btns = 8'h02;
    for (int i = 0; i < 10; i++) begin tick(); pc += int'(press_pulse[3]); rc += int'(release_pulse[3]); end
    n_checks++;
    if (pc != 0 || rc != 0 || btn_state !== 8'h02 || leds !== 8'h00) begin
      n_fail++;
      $display("FAIL glitch_rejected: got press %0d rel %0d state %h leds %h required 0 0 02 00", pc, rc, btn_state, leds);
    end
    btns = 8'h0A;
    for (int i = 0; i < 4; i++) begin tick(); pc += int'(press_pulse[3]); rc += int'(release_pulse[3]); end
    btns = 8'h02;
    for (int i = 0; i < 10; i++) begin tick(); pc += int'(press_pulse[3]); rc += int'(release_pulse[3]); end
    n_checks++;
    if (pc != 1 || rc != 1 || leds !== 8'h08) begin
      n_fail++;
      $display("FAIL four_cycle_accept: got press %0d rel %0d leds %h required 1 1 08", pc, rc, leds);
    end
  endtask

  task automatic test_walking();
    logic [W-1:0] pats [12];
    logic [W-1:0] prev, exp_leds;
    int exp_p, exp_r, pc, rc;
    pats = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C};
    prev = 8'h02; exp_leds = 8'h08; exp_p = 0; exp_r = 0; pc = 0; rc = 0;
    for (int p = 0; p < 12; p++) begin
      btns = pats[p];
      exp_leds ^= pats[p] & ~prev;
      exp_p += $countones(pats[p] & ~prev);
      exp_r += $countones(prev & ~pats[p]);
      prev = pats[p];
      for (int i = 0; i < 8; i++) begin
        tick();
        pc += $countones(press_pulse);
        rc += $countones(release_pulse);
        n_checks++;
        if ((press_pulse & release_pulse) !== 8'h00) begin
          n_fail++;
          $display("FAIL walk_exclusive: press %h release %h", press_pulse, release_pulse);
        end
      end
    end
    n_checks++;
    if (pc != exp_p || rc != exp_r) begin
      n_fail++;
      $display("FAIL walk_pulse_counts: got %0d/%0d required %0d/%0d", pc, rc, exp_p, exp_r);
    end
    n_checks++;
    if (leds !== exp_leds || leds !== m_leds) begin
      n_fail++;
      $display("FAIL walk_leds: got %h required %h (model %h)", leds, exp_leds, m_leds);
    end
  endtask

  task automatic test_led_clr_collision();
    int pc;
    pc = 0;
    btns = 8'h2C;
    for (int i = 0; i < 5; i++) begin tick(); pc += int'(press_pulse[5]); end
    led_clr = 1'b1;
    tick();
    led_clr = 1'b0;
    n_checks++;
    if (pc != 0 || press_pulse !== 8'h20 || leds !== 8'h00) begin
      n_fail++;
      $display("FAIL clr_collision: got early %0d press %h leds %h required 0 20 00", pc, press_pulse, leds);
    end
    btns = 8'h0C;
    for (int i = 0; i < 8; i++) tick();
    btns = 8'h2C;
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if (leds !== 8'h20) begin
      n_fail++;
      $display("FAIL clr_then_press: got %h required 20", leds);
    end
  endtask

  task automatic test_reset_mid_count();
    int pc;
    pc = 0;
    btns = 8'h2D;
    tick(); pc += $countones(press_pulse);
    tick(); pc += $countones(press_pulse);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (pc != 0 || {btn_state, press_pulse, leds} !== 24'h0) begin
      n_fail++;
      $display("FAIL mid_count_reset: got pulses %0d state %h press %h leds %h required all 0", pc, btn_state, press_pulse, leds);
    end
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_checks++;
      if (press_pulse !== ((i == 6) ? 8'h2D : 8'h00)) begin
        n_fail++;
        $display("FAIL reaccept_latency edge %0d: got %h required %h", i, press_pulse, (i == 6) ? 8'h2D : 8'h00);
      end
    end
    n_checks++;
    if (btn_state !== 8'h2D || leds !== 8'h2D) begin
      n_fail++;
      $display("FAIL reaccept_state: got state %h leds %h required 2d 2d", btn_state, leds);
    end
  endtask

  task automatic test_random();
    int rem [W];
    for (int l = 0; l < W; l++) rem[l] = $urandom_range(1, 7);
    for (int c = 0; c < 800; c++) begin
      for (int l = 0; l < W; l++) begin
        rem[l]--;
        if (rem[l] == 0) begin
          btns[l] = ~btns[l];
          rem[l]  = $urandom_range(1, 7);
        end
      end
      led_clr = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 299) == 0);
      tick();
      n_checks++;
      if (btn_state !== m_state) begin
        n_fail++;
        $display("FAIL rand_state cyc %0d: got %h required %h", c, btn_state, m_state);
      end
      n_checks++;
      if (press_pulse !== m_press) begin
        n_fail++;
        $display("FAIL rand_press cyc %0d: got %h required %h", c, press_pulse, m_press);
      end
      n_checks++;
      if (release_pulse !== m_rel) begin
        n_fail++;
        $display("FAIL rand_release cyc %0d: got %h required %h", c, release_pulse, m_rel);
      end
      n_checks++;
      if (leds !== m_leds) begin
        n_fail++;
        $display("FAIL rand_leds cyc %0d: got %h required %h", c, leds, m_leds);
      end
    end
    rst = 1'b0; led_clr = 1'b0;
  endtask

  initial begin
    for (int j = 0; j <= DEB; j++) smp[j] = '0;
    test_reset();
    test_single_press();
    test_glitch();
    test_walking();
    test_led_clr_collision();
    test_reset_mid_count();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/btn_debounce_toggle.md
# btn_debounce_toggle

Button-side input conditioner for the board's button/LED path. It synchronises and debounces `WIDTH` raw button lines, produces one-cycle press and release pulses, and keeps a toggle register per button that drives the LEDs directly. Each press flips its LED. It replaces the purely combinational button-to-LED mapping at the board top and supplies clean, edge-qualified button events to downstream logic.

## Interface
- `WIDTH`, default 8: number of button/LED lanes.
- `DEBOUNCE_CYCLES`, default 4: consecutive differing synchronised samples required to accept a new level. Legal range is 1 or more.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: per-lane counter width. Derived; never overridden.
- `clk`  in  1: system clock. This is the only clock.
- `rst`  in  1: reset, synchronous and active-high.
- `btns`  in  WIDTH: raw asynchronous button levels, 1 = pressed.
- `led_clr`  in  1: synchronous clear of all LED toggle bits.
- `btn_state`  out  WIDTH: debounced button level per lane.
- `press_pulse`  out  WIDTH: one-cycle pulse when a lane's debounced level goes 0→1.
- `release_pulse`  out  WIDTH: one-cycle pulse when a lane's debounced level goes 1→0.
- `leds`  out  WIDTH: per-lane toggle register.

## Operation
- Per lane, a two-flop synchroniser runs `btns[i]` → `s1[i]` → `s2[i]`. No logic reads `s1`.
- Per lane, there is an independent counter `cnt[i]` (`CNT_W` bits) and a stable flop `btn_state[i]`.
- Each edge, when `s2[i] == btn_state[i]`:
  - `cnt[i]` ← 0.
- Each edge, when `s2[i] != btn_state[i]` and `cnt[i] < DEBOUNCE_CYCLES-1`:
  - `cnt[i]` ← `cnt[i]+1`.
- Each edge, when `s2[i] != btn_state[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`:
  - `btn_state[i]` ← `s2[i]`.
  - `cnt[i]` ← 0.
  - The matching pulse is asserted on the same edge: `press_pulse[i]` for a 0→1 change, `release_pulse[i]` for a 1→0 change.
- Pulses are registered. Each is high for exactly one cycle, then returns to 0. `press_pulse[i]` and `release_pulse[i]` are never high together.
- Glitch rejection: if `s2` returns to `btn_state` before the count completes, the counter clears and nothing changes. A later differing run restarts from 0.
- LED toggle, evaluated on the same edge that sets the pulse:
  - `led_clr` = 1: `leds` ← 0. This wins over any simultaneous press.
  - Otherwise `leds[i]` ← `leds[i] ^ p[i]`, where `p[i]` is the press condition being registered on this edge.
  - The LED therefore changes on the same edge as `press_pulse` rises, not one cycle later.
- Release events never change `leds`.
- Lanes are fully independent. Several lanes may flip, pulse and toggle on the same edge.
- `led_clr` has no effect on the synchronisers, counters, `btn_state` or the pulses.

## Timing
- Reset (`rst` = 1 at an edge): `s1`, `s2`, `cnt`, `btn_state`, `press_pulse`, `release_pulse` and `leds` are all 0 after that edge.
- `rst` overrides `led_clr` and all counting.
- Reset mid-debounce discards the partial count. A button still held after reset is re-accepted from scratch, which produces a fresh `press_pulse`.
- Latency: a `btns[i]` level sampled at edge k and held makes `btn_state[i]`, the pulse and `leds[i]` update at edge k+1+`DEBOUNCE_CYCLES`. For the default of 4 this is edge k+5.
- With `DEBOUNCE_CYCLES` = 1, the lane flips on the first edge where `s2` differs (edge k+2).
- Minimum accepted pulse width on `btns` is `DEBOUNCE_CYCLES` consecutive sampled cycles. Shorter pulses are rejected.
- Counter saturation is impossible: the counter clears on acceptance or on a match, so it never exceeds `DEBOUNCE_CYCLES-1`.
- Throughput: a lane can accept a new level at most once every `DEBOUNCE_CYCLES` edges.

## Test plan
Parameters: `WIDTH` = 8, `DEBOUNCE_CYCLES` = 4.
- **Reset:** hold `rst` for 3 cycles with `btns` = 8'hFF. All outputs are 0 during reset. After release, `btn_state` = 8'hFF and `press_pulse` = 8'hFF, both exactly 5 edges after the first post-reset sample. `leds` = 8'hFF.
- **Single press/release:** `btns` = 8'h02, held 10 cycles → `press_pulse` = 8'h02 for one cycle, and `leds` = 8'h02. Then `btns` = 8'h00 → `release_pulse` = 8'h02 for one cycle, and `leds` stays 8'h02. A second press → `leds` = 8'h00.
- **Glitch rejection:** `btns[3]` high for 3 cycles, then low → no pulse, and `btn_state`/`leds` are unchanged. A 4-cycle high is accepted.
- **Walking pattern:** step through 8'h02, 8'h04, …, 8'h80, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, holding each 8 cycles. Each new bit gives one press pulse and each dropped bit gives one release pulse. Final `leds` is the XOR of all accepted presses, and the checker compares it against a model.
- **led_clr collision:** assert `led_clr` on the exact edge where `press_pulse[5]` registers → `leds` = 8'h00 and `press_pulse[5]` = 1 still. The next press sets `leds[5]` = 1.
- **Reset mid-count:** raise `btns[0]`, then pulse `rst` 2 edges later → no pulse before reset. After reset, a press is accepted 5 edges after the first post-reset sample.
